// File: rtl/tlc_pkg.sv
// Shared types for the traffic light controller: phase enum, lamp codes and
// the phase-to-lamp decode used by the registered output stage.
package tlc_pkg;

   typedef enum logic [2:0] {
      ALL_RED_A = 3'd0,
      G1        = 3'd1,
      Y1        = 3'd2,
      ALL_RED_B = 3'd3,
      G2        = 3'd4,
      Y2        = 3'd5,
      FLASH     = 3'd6
   } tlc_state_e;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   // Returns {light1, light2}; flash_off selects the dark half of FLASH.
   function automatic logic [5:0] lamp_of(tlc_state_e s, logic flash_off);
      logic [5:0] l;
      case (s)
         G1:      l = {LAMP_GRN, LAMP_RED};
         Y1:      l = {LAMP_YEL, LAMP_RED};
         G2:      l = {LAMP_RED, LAMP_GRN};
         Y2:      l = {LAMP_RED, LAMP_YEL};
         FLASH:   l = flash_off ? {LAMP_OFF, LAMP_OFF} : {LAMP_YEL, LAMP_YEL};
         default: l = {LAMP_RED, LAMP_RED};
      endcase
      return l;
   endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Loadable down-counter for phase timing; decrements on tick, stops at zero.
module tlc_phase_timer #(
   parameter int               CNT_W   = 6,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   assign zero = (count == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= RST_VAL;
      else if (load)
         count <= load_val;
      else if (tick && !zero)
         count <= count - CNT_W'(1);
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light sequencer with night flashing mode.
// Optional pedestrian walk phase is built in when TLC_PED_EN is defined.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  ALL_RED_A | clearance before road 1 green (walk phase if ped latched)
//  G1        | road 1 green
//  Y1        | road 1 yellow
//  ALL_RED_B | clearance before road 2 green (walk phase if ped latched)
//  G2        | road 2 green
//  Y2        | road 2 yellow
//  FLASH     | night mode, both roads flash yellow
module traffic_light_ctrl
   import tlc_pkg::*;
#(
   parameter int GREEN_T     = 25,
   parameter int YELLOW_T    = 5,
   parameter int ALL_RED_T   = 2,
   parameter int MIN_GREEN_T = 5,
   parameter int PED_T       = 10,
   parameter int CNT_W       = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             night_mode,
`ifdef TLC_PED_EN
   input  logic             ped_req,
   output logic             ped_walk,
`endif
   output logic [2:0]       light1,
   output logic [2:0]       light2,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] GRN_LD  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YEL_LD  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] RED_LD  = CNT_W'(ALL_RED_T - 1);
   localparam logic [CNT_W-1:0] MING_LD = CNT_W'(MIN_GREEN_T - 1);
   localparam logic [CNT_W-1:0] MING    = CNT_W'(MIN_GREEN_T);
   localparam logic [CNT_W-1:0] PED_LD  = CNT_W'(PED_T - 1);

   tlc_state_e       state, state_nx;
   logic             flash, flash_nx;
   logic             ped_latch, ped_set, ped_clr;
   logic             ped_phase, ped_phase_nx;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             zero;
   logic [5:0]       lamps_nx;

`ifdef TLC_PED_EN
   assign ped_set  = ped_req;
   assign ped_walk = ped_phase;
`else
   assign ped_set  = 1'b0;
`endif

   tlc_phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (RED_LD)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .zero     (zero)
   );

   always_comb begin
      state_nx     = state;
      flash_nx     = flash;
      ped_phase_nx = ped_phase;
      ped_clr      = 1'b0;
      load         = 1'b0;
      load_val     = '0;
      if (tick) begin
         case (state)
            ALL_RED_A, ALL_RED_B: begin
               if (zero) begin
                  ped_clr      = ped_phase;
                  ped_phase_nx = 1'b0;
                  load         = 1'b1;
                  if (night_mode) begin
                     state_nx = FLASH;
                     flash_nx = 1'b0;
                     load_val = '0;
                  end else begin
                     state_nx = (state == ALL_RED_A) ? G1 : G2;
                     load_val = GRN_LD;
                  end
               end
            end
            G1, G2: begin
               if (night_mode || zero) begin
                  state_nx = (state == G1) ? Y1 : Y2;
                  load     = 1'b1;
                  load_val = YEL_LD;
               end else if (ped_latch && count >= MING) begin
                  // pedestrian waiting: cut the remaining green to the floor
                  load     = 1'b1;
                  load_val = MING_LD;
               end
            end
            Y1, Y2: begin
               if (zero) begin
                  state_nx     = (state == Y1) ? ALL_RED_B : ALL_RED_A;
                  ped_phase_nx = ped_latch;
                  load         = 1'b1;
                  load_val     = ped_latch ? PED_LD : RED_LD;
               end
            end
            FLASH: begin
               if (!night_mode) begin
                  state_nx     = ALL_RED_A;
                  ped_phase_nx = ped_latch;
                  load         = 1'b1;
                  load_val     = ped_latch ? PED_LD : RED_LD;
               end else begin
                  flash_nx = ~flash;
               end
            end
            default: begin
               state_nx = ALL_RED_A;
               load     = 1'b1;
               load_val = RED_LD;
            end
         endcase
      end
   end

   assign lamps_nx = lamp_of(state_nx, flash_nx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ALL_RED_A;
         flash     <= 1'b0;
         ped_latch <= 1'b0;
         ped_phase <= 1'b0;
         light1    <= LAMP_RED;
         light2    <= LAMP_RED;
      end else begin
         state     <= state_nx;
         flash     <= flash_nx;
         ped_latch <= ped_set | (ped_latch & ~ped_clr);
         ped_phase <= ped_phase_nx;
         light1    <= lamps_nx[5:3];
         light2    <= lamps_nx[2:0];
      end
   end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter GREEN_T, default 25, green duration in ticks (1..2^CNT_W-1).
REQ-002 Parameter YELLOW_T, default 5, yellow duration in ticks (1..2^CNT_W-1).
REQ-003 Parameter ALL_RED_T, default 2, all-red clearance in ticks (1..2^CNT_W-1).
REQ-004 Parameter MIN_GREEN_T, default 5, green floor under pedestrian truncation (1..GREEN_T).
REQ-005 Parameter PED_T, default 10, pedestrian walk duration in ticks (>=ALL_RED_T, <=2^CNT_W-1).
REQ-006 Parameter CNT_W, default 6, width of the phase counter.
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 tick  input  1  single-cycle time-base strobe; timing advances only when tick=1.
REQ-010 night_mode  input  1  level request for flashing-yellow mode.
REQ-011 ped_req  input  1  pedestrian button pulse (only with TLC_PED_EN).
REQ-012 light1  output  3  road 1 lamps {red,yellow,green}: 100 red, 010 yellow, 001 green, 000 dark.
REQ-013 light2  output  3  road 2 lamps, same encoding.
REQ-014 count  output  CNT_W  ticks remaining in the current phase, minus one.
REQ-015 ped_walk  output  1  walk lamp; 1 only during a pedestrian all-red phase (only with TLC_PED_EN).

Function
REQ-016 States: ALL_RED_A, G1, Y1, ALL_RED_B, G2, Y2, FLASH; sequence ALL_RED_A->G1->Y1->ALL_RED_B->G2->Y2->ALL_RED_A.
REQ-017 Lamps: ALL_RED_x 100/100; G1 001/100; Y1 010/100; G2 100/001; Y2 100/010; FLASH 010/010 or 000/000 alternating.
REQ-018 On phase entry, count loads duration-1; on tick with count>0, count decrements; on tick with count==0, the next phase is entered on that same clock edge.
REQ-019 With tick=0, state, count and lamps hold.
REQ-020 Outputs are registered; lamps change on the same edge as the state change.
REQ-021 count never wraps below zero; duration value 1 gives a one-tick phase (count stays 0).
REQ-022 night_mode=1 sampled in G1/G2 forces entry to Y1/Y2 on the next tick, regardless of count.
REQ-023 night_mode=1 in Y/ALL_RED lets the phase complete; on completion of an ALL_RED phase with night_mode=1, FLASH is entered instead of G.
REQ-024 In FLASH, the lamp pattern toggles on every tick, starting with 010/010; count holds 0.
REQ-025 night_mode=0 in FLASH enters ALL_RED_A on the next tick, which then runs its full ALL_RED_T.
REQ-026 A yellow phase is never skipped; no transition goes directly from green to red or from green to FLASH.

Reset
REQ-027 While rst=1: state ALL_RED_A, count=ALL_RED_T-1, light1=light2=100, ped_walk=0, pedestrian latch cleared, flash phase bit 0.
REQ-028 Reset asserted mid-phase takes effect immediately (asynchronously); on release, operation starts with a full ALL_RED_A.

Configuration
REQ-029 Macro TLC_PED_EN defined: ped_req is set-latched on any cycle, regardless of tick; a latch set during G1/G2 with count>=MIN_GREEN_T reloads count to MIN_GREEN_T-1 on the next tick.
REQ-030 With TLC_PED_EN: the next ALL_RED phase loads PED_T-1 in place of ALL_RED_T-1, drives ped_walk=1 for its duration, and clears the latch on exit; ped_req in FLASH stays latched until after FLASH.
REQ-031 Macro TLC_PED_EN undefined: ped_req and ped_walk are absent, and behaviour is REQ-016..028 only.

Structure
REQ-032 Package tlc_pkg holds the state enum, the lamp encoding constants (LAMP_RED/YEL/GRN/OFF) and the state-to-lamp mapping function.
REQ-033 Sub-module tlc_phase_timer (CNT_W loadable down-counter with tick enable and zero flag) is instantiated once.

Verification
REQ-034 Defaults, tick every cycle, 200 cycles -> G1 for 25 ticks, Y1 for 5, ALL_RED_B for 2, G2 for 25, Y2 for 5, ALL_RED_A for 2, and a 64-tick period.
REQ-035 tick every 4th cycle -> all phase lengths are 4x in cycles, and count is stable between ticks.
REQ-036 night_mode=1 at G1 count=20 -> Y1 for 5 ticks, ALL_RED_B for 2, then FLASH toggling 010/010 and 000/000; release -> ALL_RED_A for 2, then G1.
REQ-037 TLC_PED_EN: ped_req at G2 count=18 -> count becomes 4, Y2 for 5, ALL_RED_A for 10 with ped_walk=1, then G1 with ped_walk=0; ped_req at G2 count=3 -> no truncation.
REQ-038 rst pulse in Y1 count=2 -> outputs are 100/100 immediately, count=1 after release, and the sequence restarts at ALL_RED_A.
